// File: rtl/hdmi_cfg_pkg.sv
// Shared types and constants for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

    typedef enum logic [2:0] {
        POWER_WAIT,
        LOAD,
        START,
        WAIT_END,
        CHECK,
        GAP,
        DONE,
        ERROR
    } cfg_state_t;

    localparam logic [7:0] ADV7513_ADDR = 8'h72;

    localparam int ADDR_W    = 8;
    localparam int REG_W     = 8;
    localparam int VAL_W     = 8;
    localparam int ENTRY_W   = ADDR_W + REG_W + VAL_W;
    localparam int ROM_IDX_W = 8;
    localparam int CNT_W     = 20;

    // True on the last cycle of an interval of 'limit' cycles; a zero limit behaves as one cycle.
    function automatic logic count_done(input logic [CNT_W-1:0] count,
                                        input logic [CNT_W-1:0] limit);
        logic [CNT_W:0] next_count;
        next_count = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
        return next_count >= {1'b0, limit};
    endfunction

endpackage

// File: rtl/hdmi_config_rom.sv
// ADV7513 power-up register table: index -> {slave_addr, reg_addr, reg_value}.
module hdmi_config_rom
    import hdmi_cfg_pkg::*;
(
    input  logic [ROM_IDX_W-1:0] index,
    output logic [ENTRY_W-1:0]   entry
);

    always_comb begin
        entry = {ADV7513_ADDR, 8'h00, 8'h00};
        case (index)
            8'd0:    entry = {ADV7513_ADDR, 8'h41, 8'h10};
            8'd1:    entry = {ADV7513_ADDR, 8'h98, 8'h03};
            8'd2:    entry = {ADV7513_ADDR, 8'h9A, 8'hE0};
            8'd3:    entry = {ADV7513_ADDR, 8'h9C, 8'h30};
            8'd4:    entry = {ADV7513_ADDR, 8'h9D, 8'h61};
            8'd5:    entry = {ADV7513_ADDR, 8'hA2, 8'hA4};
            8'd6:    entry = {ADV7513_ADDR, 8'hA3, 8'hA4};
            8'd7:    entry = {ADV7513_ADDR, 8'hE0, 8'hD0};
            8'd8:    entry = {ADV7513_ADDR, 8'hF9, 8'h00};
            8'd9:    entry = {ADV7513_ADDR, 8'h15, 8'h00};
            8'd10:   entry = {ADV7513_ADDR, 8'h16, 8'h70};
            8'd11:   entry = {ADV7513_ADDR, 8'h17, 8'h02};
            8'd12:   entry = {ADV7513_ADDR, 8'h18, 8'h46};
            8'd13:   entry = {ADV7513_ADDR, 8'hAF, 8'h06};
            8'd14:   entry = {ADV7513_ADDR, 8'hBA, 8'h60};
            8'd15:   entry = {ADV7513_ADDR, 8'hD0, 8'h3C};
            8'd16:   entry = {ADV7513_ADDR, 8'hD1, 8'hFF};
            8'd17:   entry = {ADV7513_ADDR, 8'hDE, 8'h9C};
            8'd18:   entry = {ADV7513_ADDR, 8'hE4, 8'h60};
            8'd19:   entry = {ADV7513_ADDR, 8'hFA, 8'h7D};
            8'd20:   entry = {ADV7513_ADDR, 8'h55, 8'h12};
            8'd21:   entry = {ADV7513_ADDR, 8'h56, 8'h08};
            8'd22:   entry = {ADV7513_ADDR, 8'h96, 8'h20};
            8'd23:   entry = {ADV7513_ADDR, 8'h3B, 8'h00};
            8'd24:   entry = {ADV7513_ADDR, 8'h3C, 8'h00};
            8'd25:   entry = {ADV7513_ADDR, 8'h40, 8'h80};
            8'd26:   entry = {ADV7513_ADDR, 8'h4C, 8'h04};
            8'd27:   entry = {ADV7513_ADDR, 8'h94, 8'hC0};
            8'd28:   entry = {ADV7513_ADDR, 8'hD6, 8'hC0};
            8'd29:   entry = {ADV7513_ADDR, 8'h49, 8'hA8};
            8'd30:   entry = {ADV7513_ADDR, 8'h41, 8'h10};
            default: entry = {ADV7513_ADDR, 8'h00, 8'h00};
        endcase
    end

endmodule

// File: rtl/hdmi_config_sequencer.sv
// Walks the ADV7513 register ROM through the I2C write controller with ack checking and retries.
// Optional HDMI_HPD_RECONFIG_EN adds hdmi_hpd: rising edge restarts, falling edge aborts.
module hdmi_config_sequencer
    import hdmi_cfg_pkg::*;
#(
    parameter int              LUT_SIZE        = 31,
    parameter int              RETRY_MAX       = 3,
    parameter logic [19:0]     PWR_WAIT_CYCLES = 20'd1000000,
    parameter logic [19:0]     TIMEOUT_CYCLES  = 20'd100000,
    parameter logic [15:0]     GAP_CYCLES      = 16'd1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ENTRY_W-1:0] i2c_data,
    output logic               i2c_enable,
    output logic               i2c_reset,
    input  logic               i2c_ack,
    input  logic               i2c_end,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [7:0]         err_index
`ifdef HDMI_HPD_RECONFIG_EN
    ,
    input  logic               hdmi_hpd
`endif
);

    localparam int IDX_W   = $clog2(LUT_SIZE + 1);
    localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    localparam logic [IDX_W-1:0]   END_INDEX   = IDX_W'(LUT_SIZE);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(RETRY_MAX);
    localparam logic [CNT_W-1:0]   GAP_LIMIT   = CNT_W'(GAP_CYCLES);

    cfg_state_t         state;
    cfg_state_t         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   index;
    logic [RETRY_W-1:0] retry;
    logic               end_prev;
    logic               end_rise;
    logic               ack_ok;
    logic [ENTRY_W-1:0] rom_entry;

    logic restart_req;
    logic abort_req;
    logic load_entry;
    logic clear_seq;
    logic entry_ok;
    logic entry_retry;
    logic enter_error;

    hdmi_config_rom u_rom (
        .index (ROM_IDX_W'(index)),
        .entry (rom_entry)
    );

`ifdef HDMI_HPD_RECONFIG_EN
    // hpd_sync[1] is the synchronised level, hpd_sync[2] its previous value for edge detection.
    logic [2:0] hpd_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            hpd_sync <= 3'b000;
        end else begin
            hpd_sync <= {hpd_sync[1:0], hdmi_hpd};
        end
    end

    assign restart_req = start | (hpd_sync[1] & ~hpd_sync[2]);
    assign abort_req   = ~hpd_sync[1] & hpd_sync[2];
`else
    assign restart_req = start;
    assign abort_req   = 1'b0;
`endif

    assign end_rise = i2c_end & ~end_prev;
    assign done     = (state == DONE);
    assign error    = (state == ERROR);

    always_comb begin
        state_next  = state;
        load_entry  = 1'b0;
        clear_seq   = 1'b0;
        entry_ok    = 1'b0;
        entry_retry = 1'b0;
        enter_error = 1'b0;
        i2c_enable  = 1'b0;
        i2c_reset   = 1'b0;

        case (state)
            POWER_WAIT: begin
                i2c_reset = 1'b1;
                if (count_done(cnt, PWR_WAIT_CYCLES)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                i2c_reset  = 1'b1;
                load_entry = 1'b1;
                state_next = START;
            end
            START: begin
                i2c_enable = 1'b1;
                state_next = WAIT_END;
            end
            WAIT_END: begin
                i2c_enable = 1'b1;
                if (end_rise || count_done(cnt, TIMEOUT_CYCLES)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                i2c_enable = 1'b1;
                if (ack_ok) begin
                    entry_ok   = 1'b1;
                    state_next = GAP;
                end else if (retry < RETRY_LIMIT) begin
                    entry_retry = 1'b1;
                    state_next  = GAP;
                end else begin
                    enter_error = 1'b1;
                    state_next  = ERROR;
                end
            end
            GAP: begin
                if (count_done(cnt, GAP_LIMIT)) begin
                    state_next = (index == END_INDEX) ? DONE : LOAD;
                end
            end
            DONE, ERROR: begin
                i2c_reset = 1'b1;
                if (restart_req) begin
                    clear_seq  = 1'b1;
                    state_next = POWER_WAIT;
                end
            end
            default: begin
                state_next = POWER_WAIT;
            end
        endcase

        // Losing the sink mid-sequence throws away all progress; restart from power-up.
        if (abort_req && (state != DONE) && (state != ERROR)) begin
            clear_seq   = 1'b1;
            entry_ok    = 1'b0;
            entry_retry = 1'b0;
            enter_error = 1'b0;
            state_next  = POWER_WAIT;
        end
    end

    // One shared interval counter: restarts on every state change, serving power-up, timeout and gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= POWER_WAIT;
            cnt       <= '0;
            index     <= '0;
            retry     <= '0;
            end_prev  <= 1'b0;
            ack_ok    <= 1'b0;
            i2c_data  <= '0;
            busy      <= 1'b0;
            err_index <= 8'h00;
        end else begin
            state <= state_next;
            busy  <= (state_next != DONE) && (state_next != ERROR);

            if ((state_next != state) || clear_seq) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            end_prev <= (state == LOAD) ? 1'b0 : i2c_end;

            if (state == WAIT_END) begin
                ack_ok <= end_rise & i2c_ack;
            end

            if (load_entry) begin
                i2c_data <= rom_entry;
            end

            if (clear_seq) begin
                index     <= '0;
                retry     <= '0;
                err_index <= 8'h00;
            end else begin
                if (entry_ok) begin
                    index <= index + IDX_W'(1);
                    retry <= '0;
                end
                if (entry_retry) begin
                    retry <= retry + RETRY_W'(1);
                end
                if (enter_error) begin
                    err_index <= 8'(index);
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Directed bench for hdmi_config_sequencer with a hand-driven I2C controller model.
module tb_hdmi_config_sequencer;
    import hdmi_cfg_pkg::*;

    localparam int          LUT     = 4;
    localparam int          RETRIES = 3;
    localparam logic [19:0] PWR     = 20'd10;
    localparam logic [19:0] TMO     = 20'd20;
    localparam logic [15:0] GAPC    = 16'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        i2c_ack = 1'b0;
    logic        i2c_end = 1'b0;
    logic [23:0] i2c_data;
    logic        i2c_enable;
    logic        i2c_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  err_index;
`ifdef HDMI_HPD_RECONFIG_EN
    logic        hdmi_hpd = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic [23:0] rom_exp [4] = '{24'h724110, 24'h729803, 24'h729AE0, 24'h729C30};

    always #5 clk = ~clk;

    hdmi_config_sequencer #(
        .LUT_SIZE        (LUT),
        .RETRY_MAX       (RETRIES),
        .PWR_WAIT_CYCLES (PWR),
        .TIMEOUT_CYCLES  (TMO),
        .GAP_CYCLES      (GAPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .i2c_data   (i2c_data),
        .i2c_enable (i2c_enable),
        .i2c_reset  (i2c_reset),
        .i2c_ack    (i2c_ack),
        .i2c_end    (i2c_end),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_index  (err_index)
`ifdef HDMI_HPD_RECONFIG_EN
        ,
        .hdmi_hpd   (hdmi_hpd)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_enable(input int budget, output bit seen, output logic prev_rst);
        seen     = 1'b0;
        prev_rst = 1'bx;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (i2c_enable === 1'b1) seen = 1'b1;
            else prev_rst = i2c_reset;
        end
    endtask

    task automatic wait_enable_low(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (i2c_enable === 1'b0) seen = 1'b1;
        end
    endtask

    task automatic wait_finished(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) seen = 1'b1;
        end
    endtask

    // Controller model: end rises two cycles into the transfer unless it stays silent.
    task automatic apply_stimulus(input string tag, input logic [23:0] exp_data, input bit respond, input bit ack);
        bit   seen;
        logic prev_rst;
        wait_enable(200, seen, prev_rst);
        check_output({tag, " enable"}, 32'(seen), 32'd1);
        if (seen) begin
            check_output({tag, " data"}, {8'h00, i2c_data}, {8'h00, exp_data});
            check_output({tag, " reset pulse"}, 32'(prev_rst), 32'd1);
            if (respond) begin
                repeat (2) @(negedge clk);
                i2c_ack = ack;
                i2c_end = 1'b1;
            end
            wait_enable_low(int'(TMO) + 20, seen);
            check_output({tag, " release"}, 32'(seen), 32'd1);
            i2c_end = 1'b0;
            i2c_ack = 1'b0;
        end
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output({tag, " done cleared"}, 32'(done), 32'd0);
        check_output({tag, " error cleared"}, 32'(error), 32'd0);
        check_output({tag, " err_index cleared"}, 32'(err_index), 32'd0);
        check_output({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic expect_done(input string tag);
        bit seen;
        wait_finished(100, seen);
        check_output({tag, " finished"}, 32'(seen), 32'd1);
        check_output({tag, " done"}, 32'(done), 32'd1);
        check_output({tag, " error"}, 32'(error), 32'd0);
        check_output({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_error(input string tag, input logic [7:0] idx);
        bit seen;
        wait_finished(100, seen);
        check_output({tag, " finished"}, 32'(seen), 32'd1);
        check_output({tag, " error"}, 32'(error), 32'd1);
        check_output({tag, " done"}, 32'(done), 32'd0);
        check_output({tag, " err_index"}, 32'(err_index), 32'(idx));
        check_output({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit   seen;
        logic prev_rst;
        int   en_count;

        $display("[TB] reset checks");
        repeat (3) @(negedge clk);
        check_output("rst i2c_data", {8'h00, i2c_data}, 32'd0);
        check_output("rst i2c_enable", 32'(i2c_enable), 32'd0);
        check_output("rst i2c_reset", 32'(i2c_reset), 32'd1);
        check_output("rst busy", 32'(busy), 32'd0);
        check_output("rst done", 32'(done), 32'd0);
        check_output("rst error", 32'(error), 32'd0);
        check_output("rst err_index", 32'(err_index), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("post-rst busy", 32'(busy), 32'd1);
        check_output("post-rst i2c_reset", 32'(i2c_reset), 32'd1);

        $display("[TB] all entries acknowledged");
        for (int i = 0; i < LUT; i++) apply_stimulus($sformatf("t1 e%0d", i), rom_exp[i], 1'b1, 1'b1);
        expect_done("t1");

        $display("[TB] single NACK on entry 2");
        pulse_start("t2");
        apply_stimulus("t2 e0", rom_exp[0], 1'b1, 1'b1);
        apply_stimulus("t2 e1", rom_exp[1], 1'b1, 1'b1);
        apply_stimulus("t2 e2 nack", rom_exp[2], 1'b1, 1'b0);
        apply_stimulus("t2 e2 retry", rom_exp[2], 1'b1, 1'b1);
        apply_stimulus("t2 e3", rom_exp[3], 1'b1, 1'b1);
        expect_done("t2");

        $display("[TB] persistent NACK on entry 1");
        pulse_start("t3");
        apply_stimulus("t3 e0", rom_exp[0], 1'b1, 1'b1);
        for (int r = 0; r <= RETRIES; r++) apply_stimulus($sformatf("t3 e1 try%0d", r), rom_exp[1], 1'b1, 1'b0);
        expect_error("t3", 8'd1);
        en_count = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i2c_enable === 1'b1) en_count++;
        end
        check_output("t3 idle after error", 32'(en_count), 32'd0);

        $display("[TB] controller timeout on entry 1");
        pulse_start("t4");
        apply_stimulus("t4 e0", rom_exp[0], 1'b1, 1'b1);
        for (int r = 0; r <= RETRIES; r++) apply_stimulus($sformatf("t4 e1 tmo%0d", r), rom_exp[1], 1'b0, 1'b0);
        expect_error("t4", 8'd1);

        $display("[TB] reset during entry 2");
        pulse_start("t5");
        apply_stimulus("t5 e0", rom_exp[0], 1'b1, 1'b1);
        apply_stimulus("t5 e1", rom_exp[1], 1'b1, 1'b1);
        wait_enable(200, seen, prev_rst);
        check_output("t5 e2 enable", 32'(seen), 32'd1);
        check_output("t5 e2 data", {8'h00, i2c_data}, {8'h00, rom_exp[2]});
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("t5 abort enable", 32'(i2c_enable), 32'd0);
        check_output("t5 abort i2c_reset", 32'(i2c_reset), 32'd1);
        check_output("t5 abort busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < LUT; i++) apply_stimulus($sformatf("t5 rerun e%0d", i), rom_exp[i], 1'b1, 1'b1);
        expect_done("t5");

        $display("[TB] start while busy is ignored");
        pulse_start("t6");
        apply_stimulus("t6 e0", rom_exp[0], 1'b1, 1'b1);
        wait_enable(200, seen, prev_rst);
        check_output("t6 e1 enable", 32'(seen), 32'd1);
        check_output("t6 e1 data", {8'h00, i2c_data}, {8'h00, rom_exp[1]});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i2c_ack = 1'b1;
        i2c_end = 1'b1;
        wait_enable_low(40, seen);
        check_output("t6 e1 release", 32'(seen), 32'd1);
        i2c_end = 1'b0;
        i2c_ack = 1'b0;
        apply_stimulus("t6 e2", rom_exp[2], 1'b1, 1'b1);
        apply_stimulus("t6 e3", rom_exp[3], 1'b1, 1'b1);
        expect_done("t6");

`ifdef HDMI_HPD_RECONFIG_EN
        $display("[TB] HPD rising edge after done");
        hdmi_hpd = 1'b1;
        repeat (4) @(negedge clk);
        check_output("t7 busy", 32'(busy), 32'd1);
        check_output("t7 done cleared", 32'(done), 32'd0);
        for (int i = 0; i < LUT; i++) apply_stimulus($sformatf("t7 e%0d", i), rom_exp[i], 1'b1, 1'b1);
        expect_done("t7");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
